// File: rtl/nock_dispatch.sv
// nock_dispatch: dispatches one formula node to the Nock operator blocks.
// The node's head is decoded as an opcode and the matching operator is
// launched through the shared mux select. The dispatcher then waits for the
// operator's finished pulse, captures its return sys-func/state and hands
// control back to traversal. Faults are reported on a sticky error code.
//
// Node word layout (DATA_W = 2*(NOUN_W+1)):
//   [DATA_W-1]              hed tag (0 = atom, 1 = cell)
//   [DATA_W-2 -: NOUN_W]    hed value (opcode)
//   [NOUN_W]                tel tag
//   [NOUN_W-1:0]            tel value (operand)
//
// Optional feature: define NOCK_DISPATCH_TIMEOUT_EN to abort a WAIT that
// runs for TIMEOUT_CYCLES cycles without a finished pulse (error 8'h03).
module nock_dispatch #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_W         = 16,
    parameter int NOUN_W         = 31,
    parameter int DATA_W         = 2 * (NOUN_W + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              disp_start_i,
    input  logic [ADDR_W-1:0] disp_address_i,
    input  logic [DATA_W-1:0] disp_data_i,
    output logic [2:0]        mux_sel_o,
    output logic [ADDR_W-1:0] child_address_o,
    output logic [DATA_W-1:0] child_data_o,
    input  logic              child_finished_i,
    input  logic [3:0]        child_return_sys_func_i,
    input  logic [3:0]        child_return_state_i,
    input  logic [7:0]        child_error_i,
    output logic              disp_busy_o,
    output logic              disp_done_o,
    output logic [3:0]        ret_sys_func_o,
    output logic [3:0]        ret_state_o,
    output logic [7:0]        disp_error_o
);

    localparam logic [2:0] MUX_TRAVERSAL = 3'd0;
    localparam logic [2:0] MUX_CELL      = 3'd1;
    localparam logic [2:0] MUX_INCR      = 3'd2;
    localparam logic [2:0] MUX_EQUAL     = 3'd3;
    localparam logic       TAG_ATOM      = 1'b0;

    localparam logic [7:0] ERR_NONE      = 8'h00;
    localparam logic [7:0] ERR_OPCODE    = 8'h01;
    localparam logic [7:0] ERR_HED_CELL  = 8'h02;
    localparam logic [7:0] ERR_TIMEOUT   = 8'h03;
    localparam logic [7:0] ERR_CHILD     = 8'h04;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_WAIT   = 2'd2,
        S_ERROR  = 2'd3
    } state_e;

    state_e              state_q,   state_d;
    logic [2:0]          mux_sel_q, mux_sel_d;
    logic [ADDR_W-1:0]   caddr_q,   caddr_d;
    logic [DATA_W-1:0]   cdata_q,   cdata_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [3:0]          ret_sf_q,  ret_sf_d;
    logic [3:0]          ret_st_q,  ret_st_d;
    logic [7:0]          err_q,     err_d;

    logic                hed_tag_s;
    logic [NOUN_W-1:0]   hed_s;

`ifdef NOCK_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counts completed WAIT cycles; saturates at TIMEOUT_CYCLES.
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]    tmo_inc_s;
    assign tmo_inc_s = tmo_cnt_q + CNT_W'(1);
`endif

    // Opcode is decoded from the latched node, never from the live input.
    assign hed_tag_s = cdata_q[DATA_W-1];
    assign hed_s     = cdata_q[DATA_W-2 -: NOUN_W];

    // Next-state and next-output logic for the dispatch sequence.
    always_comb begin
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        caddr_d   = caddr_q;
        cdata_d   = cdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ret_sf_d  = ret_sf_q;
        ret_st_d  = ret_st_q;
        err_d     = err_q;
`ifdef NOCK_DISPATCH_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                mux_sel_d = MUX_TRAVERSAL;
                if (disp_start_i) begin
                    caddr_d = disp_address_i;
                    cdata_d = disp_data_i;
                    busy_d  = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_DECODE: begin
`ifdef NOCK_DISPATCH_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                if (hed_tag_s != TAG_ATOM) begin
                    err_d   = ERR_HED_CELL;
                    state_d = S_ERROR;
                end else if (hed_s == NOUN_W'(32'd3)) begin
                    mux_sel_d = MUX_CELL;
                    state_d   = S_WAIT;
                end else if (hed_s == NOUN_W'(32'd4)) begin
                    mux_sel_d = MUX_INCR;
                    state_d   = S_WAIT;
                end else if (hed_s == NOUN_W'(32'd5)) begin
                    mux_sel_d = MUX_EQUAL;
                    state_d   = S_WAIT;
                end else begin
                    err_d   = ERR_OPCODE;
                    state_d = S_ERROR;
                end
            end
            S_WAIT: begin
                // Finish has priority over a simultaneous error or timeout.
                if (child_finished_i) begin
                    ret_sf_d  = child_return_sys_func_i;
                    ret_st_d  = child_return_state_i;
                    mux_sel_d = MUX_TRAVERSAL;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (child_error_i != ERR_NONE) begin
                    err_d     = ERR_CHILD;
                    mux_sel_d = MUX_TRAVERSAL;
                    state_d   = S_ERROR;
`ifdef NOCK_DISPATCH_TIMEOUT_EN
                end else if (tmo_inc_s == CNT_W'(TIMEOUT_CYCLES)) begin
                    err_d     = ERR_TIMEOUT;
                    mux_sel_d = MUX_TRAVERSAL;
                    state_d   = S_ERROR;
                end else begin
                    if (tmo_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
                        tmo_cnt_d = tmo_inc_s;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q;
                    end
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_ERROR: begin
                // Sticky until reset: operators stay parked, requests ignored.
                mux_sel_d = MUX_TRAVERSAL;
                busy_d    = 1'b1;
                state_d   = S_ERROR;
            end
            default: begin
                mux_sel_d = MUX_TRAVERSAL;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the operator code at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mux_sel_q <= MUX_TRAVERSAL;
            caddr_q   <= '0;
            cdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ret_sf_q  <= 4'd0;
            ret_st_q  <= 4'd0;
            err_q     <= ERR_NONE;
`ifdef NOCK_DISPATCH_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            caddr_q   <= caddr_d;
            cdata_q   <= cdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ret_sf_q  <= ret_sf_d;
            ret_st_q  <= ret_st_d;
            err_q     <= err_d;
`ifdef NOCK_DISPATCH_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

    assign mux_sel_o       = mux_sel_q;
    assign child_address_o = caddr_q;
    assign child_data_o    = cdata_q;
    assign disp_busy_o     = busy_q;
    assign disp_done_o     = done_q;
    assign ret_sys_func_o  = ret_sf_q;
    assign ret_state_o     = ret_st_q;
    assign disp_error_o    = err_q;

endmodule

// File: tb/tb_nock_dispatch.sv
// Self-checking bench for nock_dispatch: directed stimulus, a cycle-timed
// behavioural model compared on every falling edge, plus literal checks.
module tb_nock_dispatch;

    localparam int TO = 16;
`ifdef NOCK_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_start = 1'b0;
    logic [15:0] disp_address = 16'h0;
    logic [63:0] disp_data = 64'h0;
    logic [2:0]  mux_sel;
    logic [15:0] child_address;
    logic [63:0] child_data;
    logic        child_finished = 1'b0;
    logic [3:0]  child_sf = 4'h0;
    logic [3:0]  child_st = 4'h0;
    logic [7:0]  child_error = 8'h0;
    logic        disp_busy, disp_done;
    logic [3:0]  ret_sf, ret_st;
    logic [7:0]  disp_error;

    int n_cmp = 0;
    int n_fail = 0;

    nock_dispatch #(.TIMEOUT_CYCLES(TO), .ADDR_W(16), .NOUN_W(31)) dut (
        .clk_i(clk), .rst_i(rst),
        .disp_start_i(disp_start), .disp_address_i(disp_address), .disp_data_i(disp_data),
        .mux_sel_o(mux_sel), .child_address_o(child_address), .child_data_o(child_data),
        .child_finished_i(child_finished), .child_return_sys_func_i(child_sf),
        .child_return_state_i(child_st), .child_error_i(child_error),
        .disp_busy_o(disp_busy), .disp_done_o(disp_done),
        .ret_sys_func_o(ret_sf), .ret_state_o(ret_st), .disp_error_o(disp_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic tag, input logic [30:0] hed);
        return {tag, hed, 1'b0, 31'h0000_1234};
    endfunction

    // ---------------- behavioural model ----------------
    int          cyc = 0;
    int          t0 = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [2:0]  m_mux = 3'd0;
    logic [3:0]  m_sf = 4'd0, m_st = 4'd0;
    logic [7:0]  m_err = 8'd0;
    logic [15:0] m_addr = 16'd0;
    logic [63:0] m_data = 64'd0;
    logic [2:0]  m_code = 3'd0;
    logic [7:0]  m_dec_err = 8'd0;

    // Opcode table: atom 3/4/5 -> cell/incr/equal, cell head -> 02, else 01.
    function automatic void decode(input logic [63:0] d, output logic [2:0] code,
                                   output logic [7:0] e);
        logic [30:0] hed;
        hed = d[62:32];
        code = 3'd0;
        e = 8'h00;
        if (d[63]) e = 8'h02;
        else if (hed == 31'd3) code = 3'd1;
        else if (hed == 31'd4) code = 3'd2;
        else if (hed == 31'd5) code = 3'd3;
        else e = 8'h01;
    endfunction

    // Timing rules: accept at edge t0, operator code from t0+1, then the
    // k-th waiting edge is t0+1+k; a timeout fires at k == TO.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_mux = 3'd0; m_sf = 4'd0; m_st = 4'd0;
            m_err = 8'd0; m_addr = 16'd0; m_data = 64'd0;
        end else begin
            cyc++;
            m_done = 1'b0;
            if (m_err == 8'd0) begin
                if (!m_busy) begin
                    if (disp_start) begin
                        m_busy = 1'b1; m_addr = disp_address; m_data = disp_data; t0 = cyc;
                        decode(disp_data, m_code, m_dec_err);
                    end
                end else if (cyc == t0 + 1) begin
                    if (m_dec_err != 8'd0) m_err = m_dec_err;
                    else m_mux = m_code;
                end else begin
                    if (child_finished) begin
                        m_sf = child_sf; m_st = child_st; m_mux = 3'd0;
                        m_done = 1'b1; m_busy = 1'b0;
                    end else if (child_error != 8'd0) begin
                        m_err = 8'h04; m_mux = 3'd0;
                    end else if (TO_EN && (cyc - (t0 + 1) == TO)) begin
                        m_err = 8'h03; m_mux = 3'd0;
                    end
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial forever begin
        @(negedge clk);
        chk("m_mux",   64'(mux_sel),       64'(m_mux));
        chk("m_busy",  64'(disp_busy),     64'(m_busy));
        chk("m_done",  64'(disp_done),     64'(m_done));
        chk("m_err",   64'(disp_error),    64'(m_err));
        chk("m_rsf",   64'(ret_sf),        64'(m_sf));
        chk("m_rst",   64'(ret_st),        64'(m_st));
        chk("m_caddr", 64'(child_address), 64'(m_addr));
        chk("m_cdata", child_data,         m_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic start(input logic [15:0] a, input logic [63:0] d);
        disp_start = 1'b1; disp_address = a; disp_data = d;
        tick();
        disp_start = 1'b0;
    endtask

    task automatic wait_mux(input logic [2:0] code, input int budget);
        int i;
        i = 0;
        while (mux_sel != code && i < budget) begin
            tick();
            i++;
        end
        if (mux_sel != code) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_mux: got %0d expected %0d within %0d cycles", mux_sel, code, budget);
        end
    endtask

    task automatic finish_pulse(input logic [3:0] sf, input logic [3:0] st, input logic [7:0] e);
        child_finished = 1'b1; child_sf = sf; child_st = st; child_error = e;
        tick();
        child_finished = 1'b0; child_error = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gap;
        // Reset state
        tick();
        chk("rst_mux", 64'(mux_sel), 64'h0);
        chk("rst_busy", 64'(disp_busy), 64'h0);
        chk("rst_err", 64'(disp_error), 64'h0);
        chk("rst_done", 64'(disp_done), 64'h0);
        tick();
        rst = 1'b0;

        // Increment, finish 5 cycles after MUX_INCR (SYS_FUNC_READ=1, SYS_READ_INIT=2)
        start(16'h0010, mk(1'b0, 31'd4));
        chk("t1_caddr", 64'(child_address), 64'h10);
        chk("t1_busy", 64'(disp_busy), 64'h1);
        chk("t1_mux_pre", 64'(mux_sel), 64'h0);
        tick();
        chk("t1_mux", 64'(mux_sel), 64'h2);
        repeat (4) tick();
        finish_pulse(4'd1, 4'd2, 8'h00);
        chk("t1_done", 64'(disp_done), 64'h1);
        chk("t1_rsf", 64'(ret_sf), 64'h1);
        chk("t1_rst", 64'(ret_st), 64'h2);
        chk("t1_mux_back", 64'(mux_sel), 64'h0);
        chk("t1_busy_off", 64'(disp_busy), 64'h0);
        tick();
        chk("t1_done_off", 64'(disp_done), 64'h0);

        // Back-to-back dispatches of the same opcode
        start(16'h0020, mk(1'b0, 31'd4));
        wait_mux(3'd2, 4);
        repeat (2) tick();
        finish_pulse(4'd1, 4'd2, 8'h00);
        chk("t2_done1", 64'(disp_done), 64'h1);
        gap = 0;
        if (mux_sel == 3'd0) gap++;
        start(16'h0024, mk(1'b0, 31'd4));
        if (mux_sel == 3'd0) gap++;
        tick();
        chk("t2_mux2", 64'(mux_sel), 64'h2);
        chk("t2_gap", 64'(gap), 64'h2);
        repeat (3) tick();
        finish_pulse(4'd3, 4'd4, 8'h00);
        chk("t2_done2", 64'(disp_done), 64'h1);
        chk("t2_rsf", 64'(ret_sf), 64'h3);
        chk("t2_caddr", 64'(child_address), 64'h24);

        // Cell-tagged head -> 02, later start ignored
        start(16'h0030, mk(1'b1, 31'd3));
        tick();
        chk("t3_err", 64'(disp_error), 64'h2);
        chk("t3_busy", 64'(disp_busy), 64'h1);
        start(16'h0034, mk(1'b0, 31'd4));
        repeat (3) tick();
        chk("t3_mux", 64'(mux_sel), 64'h0);
        chk("t3_caddr", 64'(child_address), 64'h30);
        do_reset();

        // Bad opcode 9 -> 01; finish and start both ignored
        start(16'h0040, mk(1'b0, 31'd9));
        tick();
        chk("t4_err", 64'(disp_error), 64'h1);
        finish_pulse(4'd5, 4'd5, 8'h00);
        chk("t4_done", 64'(disp_done), 64'h0);
        chk("t4_rsf", 64'(ret_sf), 64'h0);
        start(16'h0044, mk(1'b0, 31'd5));
        repeat (3) tick();
        chk("t4_mux", 64'(mux_sel), 64'h0);
        do_reset();

        // Finish in IDLE ignored; finish+error -> finish wins; error alone -> 04
        finish_pulse(4'd7, 4'd7, 8'h00);
        chk("t5_idle_done", 64'(disp_done), 64'h0);
        start(16'h0050, mk(1'b0, 31'd5));
        wait_mux(3'd3, 4);
        tick();
        finish_pulse(4'd6, 4'd7, 8'h07);
        chk("t5_done", 64'(disp_done), 64'h1);
        chk("t5_err0", 64'(disp_error), 64'h0);
        chk("t5_rst", 64'(ret_st), 64'h7);
        start(16'h0054, mk(1'b0, 31'd5));
        wait_mux(3'd3, 4);
        child_error = 8'h07;
        tick();
        child_error = 8'h00;
        chk("t5_err4", 64'(disp_error), 64'h4);
        chk("t5_mux", 64'(mux_sel), 64'h0);
        chk("t5_busy", 64'(disp_busy), 64'h1);
        do_reset();

`ifdef NOCK_DISPATCH_TIMEOUT_EN
        // Timeout after exactly 16 WAIT cycles; finish on cycle 16 wins
        start(16'h0060, mk(1'b0, 31'd3));
        wait_mux(3'd1, 4);
        repeat (15) tick();
        chk("t6_err_pre", 64'(disp_error), 64'h0);
        chk("t6_mux_pre", 64'(mux_sel), 64'h1);
        tick();
        chk("t6_err_to", 64'(disp_error), 64'h3);
        chk("t6_mux_to", 64'(mux_sel), 64'h0);
        do_reset();
        start(16'h0064, mk(1'b0, 31'd3));
        wait_mux(3'd1, 4);
        repeat (15) tick();
        finish_pulse(4'd2, 4'd3, 8'h00);
        chk("t6_done", 64'(disp_done), 64'h1);
        chk("t6_err_none", 64'(disp_error), 64'h0);
`else
        // Without the timeout, WAIT holds indefinitely
        start(16'h0060, mk(1'b0, 31'd3));
        wait_mux(3'd1, 4);
        repeat (40) tick();
        chk("t6_err_none", 64'(disp_error), 64'h0);
        chk("t6_busy", 64'(disp_busy), 64'h1);
        chk("t6_mux", 64'(mux_sel), 64'h1);
        finish_pulse(4'd2, 4'd3, 8'h00);
        chk("t6_done", 64'(disp_done), 64'h1);
`endif

        // Asynchronous reset mid-WAIT, then a fresh dispatch
        start(16'h0070, mk(1'b0, 31'd4));
        wait_mux(3'd2, 4);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t7_mux_async", 64'(mux_sel), 64'h0);
        chk("t7_busy_async", 64'(disp_busy), 64'h0);
        chk("t7_caddr_async", 64'(child_address), 64'h0);
        tick();
        rst = 1'b0;
        start(16'h0074, mk(1'b0, 31'd5));
        wait_mux(3'd3, 4);
        tick();
        finish_pulse(4'd9, 4'd10, 8'h00);
        chk("t7_done", 64'(disp_done), 64'h1);
        chk("t7_rsf", 64'(ret_sf), 64'h9);
        chk("t7_rst", 64'(ret_st), 64'ha);
        chk("t7_caddr", 64'(child_address), 64'h74);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nock_dispatch.md
# nock_dispatch

Opcode dispatcher between memory traversal and the Nock operator blocks. Takes a formula node (address plus data word) from traversal, decodes the opcode held in the word's head, and launches the matching operator block (cell test, increment, equality) by driving the shared mux select. It also forwards the operand, waits for the operator's `finished` pulse, captures the operator's return sys-func/state, and hands control back to traversal. Decode and child faults are reported on a sticky error code.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024, max cycles in WAIT before a timeout error (used only with `NOCK_DISPATCH_TIMEOUT_EN`).

Ports:
- `clk`, in, 1, single clock, all state on rising edge.
- `rst`, in, 1, reset, asynchronous, active-high.
- `disp_start`, in, 1, traversal request; sampled in IDLE only.
- `disp_address`, in, `memory_addr_width`, address of the formula node; forwarded as result address.
- `disp_data`, in, `memory_data_width`, formula node word: hed = opcode, tel = operand.
- `mux_sel`, out, 3, shared mux select / operator start code.
- `child_address`, out, `memory_addr_width`, registered copy of `disp_address`.
- `child_data`, out, `memory_data_width`, registered copy of `disp_data`.
- `child_finished`, in, 1, one-cycle done pulse from the selected operator.
- `child_return_sys_func`, in, 4, operator's return sys-func; valid with `child_finished`.
- `child_return_state`, in, 4, operator's return state; valid with `child_finished`.
- `child_error`, in, 8, operator error code, 0 = none.
- `disp_busy`, out, 1, high from accept until `disp_done`.
- `disp_done`, out, 1, one-cycle completion pulse.
- `ret_sys_func`, out, 4, latched return sys-func.
- `ret_state`, out, 4, latched return state.
- `disp_error`, out, 8, sticky error code.

## Operation
- Reset values:
  - `mux_sel` = `MUX_TRAVERSAL`.
  - `child_address`, `child_data`, `ret_sys_func`, `ret_state`, `disp_error` = 0.
  - `disp_busy`, `disp_done` = 0.
  - State = IDLE.
- States: IDLE, DECODE, WAIT, ERROR.
- IDLE:
  - On `disp_start`, latch `disp_address`/`disp_data` into `child_*`, set `disp_busy`=1, go to DECODE.
  - `disp_done` is cleared every cycle it is not being pulsed.
- DECODE:
  - hed tag not `ATOM`: `disp_error`=8'h02, go to ERROR.
  - Otherwise compare the full hed field (`noun_width` bits, zero-extended constants):
    - 3 → `mux_sel`=`MUX_CELL`
    - 4 → `mux_sel`=`MUX_INCR`
    - 5 → `mux_sel`=`MUX_EQUAL`
    - then go to WAIT.
  - Any other value: `disp_error`=8'h01, go to ERROR.
- WAIT:
  - `mux_sel` held constant. Operators start on the edge of their code, so the code must not glitch.
  - On `child_finished`:
    - latch `ret_sys_func`/`ret_state`
    - `mux_sel`=`MUX_TRAVERSAL`, `disp_done`=1, `disp_busy`=0
    - go to IDLE.
  - `child_error` != 0 (without `child_finished`): `disp_error`=8'h04, `mux_sel`=`MUX_TRAVERSAL`, go to ERROR.
- ERROR:
  - Sticky until `rst`.
  - `disp_busy` stays 1, `mux_sel`=`MUX_TRAVERSAL`, `disp_start` ignored.
- Boundaries:
  - `disp_start` outside IDLE: ignored, no queueing.
  - `child_finished` outside WAIT: ignored.
  - `child_finished` together with nonzero `child_error`: finish wins, no error.
  - `child_finished` together with timeout: finish wins.
  - `rst` mid-operation: all outputs go to reset values immediately. The operator sees its code drop and re-arms on the next rising edge of its code.

## Timing
- `disp_start` sampled at edge N → `child_*` valid after N; `mux_sel` = operator code after edge N+1.
- `child_finished` sampled at edge M:
  - `disp_done` high for cycle M..M+1.
  - `ret_*` valid from M onward.
  - `mux_sel` = `MUX_TRAVERSAL` after M.
- Back-to-back: `disp_start` at M+1 gives the operator code again after M+2. `mux_sel` is therefore `MUX_TRAVERSAL` for ≥2 cycles between dispatches, which guarantees a fresh start edge even for the same opcode.
- Minimum dispatch overhead: 2 cycles before operator start, 0 cycles after finish.

## Configuration
- `NOCK_DISPATCH_TIMEOUT_EN` defined:
  - Saturating counter of width clog2(`TIMEOUT_CYCLES`+1), cleared on entry to WAIT, increments each WAIT cycle.
  - Reaching `TIMEOUT_CYCLES` with no `child_finished`: `disp_error`=8'h03, `mux_sel`=`MUX_TRAVERSAL`, go to ERROR.
- Not defined: no counter; WAIT waits indefinitely for `child_finished` or `child_error`.

## Test plan
- Increment: `disp_data` hed=atom 4, `disp_address`=0x10; `child_finished` 5 cycles after `mux_sel`=`MUX_INCR`, with return sys_func=`SYS_FUNC_READ`, state=`SYS_READ_INIT` → `disp_done` pulse once, `ret_*` match, `mux_sel`=`MUX_TRAVERSAL`, `child_address`=0x10.
- Back-to-back: two opcode-4 dispatches, second `disp_start` the cycle after `disp_done` → `mux_sel` drops to `MUX_TRAVERSAL` for ≥1 cycle between the two `MUX_INCR` windows; two `disp_done` pulses.
- Bad opcode: hed=atom 9 → `disp_error`=8'h01 two cycles after start, `mux_sel` never leaves `MUX_TRAVERSAL`; later `disp_start` ignored until `rst`.
- Cell opcode / child error: hed tag = cell → `disp_error`=8'h02. Separately, opcode 5 with `child_error`=8'h07 in WAIT → `disp_error`=8'h04.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): opcode 3, no finish → `disp_error`=8'h03 after exactly 16 WAIT cycles. Finish on cycle 16 instead → normal `disp_done`, no error.
- Async reset: assert `rst` mid-WAIT (between edges) → `mux_sel`=`MUX_TRAVERSAL` and `disp_busy`=0 before the next edge; a fresh dispatch afterwards completes normally.
